// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions. Holds the opcode encodings, the flag
//               bit positions, the flag vector type and the payload struct that
//               the writeback stage buffers. The sequence number is appended
//               outside the struct because its width is a module parameter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU_Sel opcode encodings
  localparam logic [3:0] ALU_SEL_ADD = 4'd0;
  localparam logic [3:0] ALU_SEL_SUB = 4'd1;
  localparam logic [3:0] ALU_SEL_MUL = 4'd2;
  localparam logic [3:0] ALU_SEL_DIV = 4'd3;
  localparam logic [3:0] ALU_SEL_AND = 4'd4;
  localparam logic [3:0] ALU_SEL_OR  = 4'd5;
  localparam logic [3:0] ALU_SEL_XOR = 4'd6;
  localparam logic [3:0] ALU_SEL_NOR = 4'd7;
  localparam logic [3:0] ALU_SEL_SLL = 4'd8;
  localparam logic [3:0] ALU_SEL_SRL = 4'd9;

  // Bit positions within the {S,V,C,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

  typedef logic [3:0] alu_flags_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  sel;
    alu_flags_t  flags;
  } alu_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_stage_if
// Description : Handshake bundle between the ALU (producer), the writeback
//               stage and the downstream consumer.
//   master : drives in_valid/in_result/in_sel/in_flags and out_ready
//   slave  : the stage; drives in_ready and the out_* head signals
// Parameters  : SEQ_W - width of out_seq
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_wb_stage_if #(
  parameter int SEQ_W = 8
) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [3:0]       in_sel;
  alu_flags_t       in_flags;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [3:0]       out_sel;
  alu_flags_t       out_flags;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output in_valid, in_result, in_sel, in_flags, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_flags, out_seq
  );

  modport slave (
    input  in_valid, in_result, in_sel, in_flags, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_flags, out_seq
  );

endinterface
`default_nettype wire

// File: rtl/alu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_fifo
// Description : Generic synchronous FIFO with explicit occupancy count.
//               Besides full/empty it exposes the head entry as it will be
//               after the current edge, so the owner can keep a registered
//               copy of the head that tracks every push and pop.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               i_push / i_pop       - requests (ignored when full / empty)
//               i_wdata              - data written on push
//               o_head_next(_valid)  - head after this edge and its validity
//               o_count, o_full, o_empty - occupancy status
// Parameters  : WIDTH, DEPTH (power of two, >= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_head_next,
  output logic                   o_head_next_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [CNT_W-1:0] w_count_next;

  assign o_full  = (r_count == c_CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_push = i_push && !o_full && !rst;
  assign w_pop  = i_pop && !o_empty;

  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_ONE;
      2'b01:   w_count_next = r_count - c_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // When the slot being written is also the next head (FIFO empty, or one
  // entry being replaced by push+pop), the new head comes from i_wdata since
  // the array does not hold it yet.
  assign o_head_next       = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? i_wdata
                                                                     : r_mem[w_rd_ptr_next];
  assign o_head_next_valid = (w_count_next != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_stage
// Description : Writeback/buffer stage behind the 32-bit ALU. Captures each
//               result with its opcode and {S,V,C,Z} flags, stamps it with a
//               wrapping sequence number and buffers it in a small FIFO so the
//               consumer can stall independently of the ALU. The head entry is
//               presented from output registers.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               bus           - alu_wb_stage_if.slave handshake bundle
//               count         - current FIFO occupancy
//               sticky_flags  - accumulated flags   (ALU_WB_STICKY_EN only)
//               sticky_clr    - clear accumulated   (ALU_WB_STICKY_EN only)
// Parameters  : DEPTH (power of two, 2..16), SEQ_W
// Options     : ALU_WB_STICKY_EN - adds the sticky status register and ports
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_wb_stage_if.slave          bus,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_WB_STICKY_EN
  ,
  output alu_flags_t             sticky_flags,
  input  logic                   sticky_clr
`endif
);

  localparam int ENTRY_W = $bits(alu_wb_entry_t) + SEQ_W;
  localparam logic [SEQ_W-1:0] c_SEQ_ONE = SEQ_W'(1);

  logic [SEQ_W-1:0]   r_seq;
  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic [3:0]         r_out_sel;
  alu_flags_t         r_out_flags;
  logic [SEQ_W-1:0]   r_out_seq;

  alu_wb_entry_t      w_entry;
  alu_wb_entry_t      w_head_entry;
  logic [SEQ_W-1:0]   w_head_seq;
  logic [ENTRY_W-1:0] w_head_next;
  logic               w_head_valid;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Ready depends only on reset and occupancy, never on out_ready.
  assign bus.in_ready = !rst && !w_full;
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = !w_empty && bus.out_ready;

  assign w_entry.result = bus.in_result;
  assign w_entry.sel    = bus.in_sel;
  assign w_entry.flags  = bus.in_flags;

  alu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .i_push            (w_push),
    .i_pop             (w_pop),
    .i_wdata           ({w_entry, r_seq}),
    .o_head_next       (w_head_next),
    .o_head_next_valid (w_head_valid),
    .o_count           (count),
    .o_full            (w_full),
    .o_empty           (w_empty)
  );

  assign {w_head_entry, w_head_seq} = w_head_next;

  // Head registers follow the FIFO head; when the FIFO drains they keep the
  // last presented entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= '0;
      r_out_flags  <= '0;
      r_out_seq    <= '0;
    end else begin
      if (w_push) begin
        r_seq <= r_seq + c_SEQ_ONE;
      end
      r_out_valid <= w_head_valid;
      if (w_head_valid) begin
        r_out_result <= w_head_entry.result;
        r_out_sel    <= w_head_entry.sel;
        r_out_flags  <= w_head_entry.flags;
        r_out_seq    <= w_head_seq;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_sel    = r_out_sel;
  assign bus.out_flags  = r_out_flags;
  assign bus.out_seq    = r_out_seq;

`ifdef ALU_WB_STICKY_EN
  alu_flags_t r_sticky;

  // A clear coinciding with a push wipes the old value before the new flags
  // are OR-ed in, so the pushed flags survive the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
    end else if (w_push) begin
      r_sticky <= (sticky_clr ? '0 : r_sticky) | bus.in_flags;
    end else if (sticky_clr) begin
      r_sticky <= '0;
    end
  end

  assign sticky_flags = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb_stage
// Description : Self-checking bench for alu_wb_stage. A driver issues
//               directed and random stimulus and pushes the expected entries
//               into a scoreboard queue; a separate monitor checks ready,
//               valid, occupancy and sticky flags each cycle and pops/compares
//               an entry whenever the consumer takes one.
// Options     : ALU_WB_STICKY_EN - also checks sticky_flags
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;
  import alu_pkg::*;

  localparam int DEPTH = 2;
  localparam int SEQ_W = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sticky_clr_drv = 1'b0;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_WB_STICKY_EN
  alu_flags_t             sticky_flags;
`endif

  alu_wb_stage_if #(.SEQ_W(SEQ_W)) bus ();

  alu_wb_stage #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count)
`ifdef ALU_WB_STICKY_EN
    ,
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr_drv)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  sel;
    logic [3:0]  flg;
    int unsigned seq;
  } exp_t;

  exp_t        q[$];
  int unsigned seq_m    = 0;
  logic [3:0]  sticky_m = 4'b0;
  bit          mdl_ready = 1'b0;
  bit          mon_en    = 1'b0;
  int          errors    = 0;
  int          checks    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus. Inputs change at the falling edge; the model
  // decides acceptance from its own occupancy before the next rising edge.
  task automatic cycle(input bit r, input bit v, input bit ordy, input bit clr,
                       input logic [31:0] res, input logic [3:0] sel, input logic [3:0] flg);
    bit acc;
    @(negedge clk);
    rst            = r;
    bus.in_valid   = v;
    bus.in_result  = res;
    bus.in_sel     = sel;
    bus.in_flags   = flg;
    bus.out_ready  = ordy;
    sticky_clr_drv = clr;
    #1;
    mdl_ready = !r && (q.size() < DEPTH);
    #2;
    if (r) begin
      q.delete();
      seq_m    = 0;
      sticky_m = 4'b0;
    end else begin
      acc = v && mdl_ready;
      if (acc) begin
        q.push_back('{res: res, sel: sel, flg: flg, seq: seq_m});
        seq_m = (seq_m + 1) % (1 << SEQ_W);
        sticky_m = (clr ? 4'b0 : sticky_m) | flg;
      end else if (clr) begin
        sticky_m = 4'b0;
      end
    end
  endtask

  task automatic rnd(input bit r, input bit v, input bit ordy, input bit clr);
    cycle(r, v, ordy, clr, 32'($urandom()), 4'($urandom_range(0, 9)), 4'($urandom()));
  endtask

  // Monitor: checks sampled mid-cycle, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, mdl_ready});
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (q.size() != 0)});
`ifdef ALU_WB_STICKY_EN
        chk("sticky_flags", 32'(sticky_flags), 32'(sticky_m));
`endif
        if (!rst && bus.out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("out_result", bus.out_result, e.res);
          chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
          chk("out_flags", 32'(bus.out_flags), 32'(e.flg));
          chk("out_seq", 32'(bus.out_seq), e.seq);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_sel    = '0;
    bus.in_flags  = '0;
    bus.out_ready = 1'b0;

    // Reset, then check the cleared state on the first idle cycle after it
    rnd(1, 0, 0, 0);
    rnd(1, 0, 0, 0);
    mon_en = 1'b1;
    rnd(0, 0, 0, 0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'h0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'h0);
    chk("rst_out_seq", 32'(bus.out_seq), 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // First push into empty FIFO, then a second
    cycle(0, 1, 1, 0, 32'h0000_0005, ALU_SEL_ADD, 4'b0000);
    cycle(0, 1, 1, 0, 32'h1234_5678, ALU_SEL_SUB, 4'b1010);
    repeat (3) rnd(0, 0, 1, 0);

    // Stall consumer, offer three entries: only two fit
    repeat (3) rnd(0, 1, 0, 0);
    repeat (4) rnd(0, 0, 1, 0);

    // Full FIFO, pop and offer a push in the same cycle
    repeat (2) rnd(0, 1, 0, 0);
    rnd(0, 1, 1, 0);
    repeat (3) rnd(0, 0, 1, 0);

    // Sticky accumulate / clear
    cycle(0, 1, 1, 0, 32'h1, ALU_SEL_MUL, 4'b0100);
    cycle(0, 1, 1, 0, 32'h2, ALU_SEL_AND, 4'b0001);
    rnd(0, 0, 1, 0);
    cycle(0, 1, 1, 1, 32'h3, ALU_SEL_OR, 4'b0010);
    rnd(0, 0, 1, 0);
    rnd(0, 0, 1, 1);
    rnd(0, 0, 1, 0);

    // Reset with two entries buffered, then first push must be seq 0
    repeat (2) rnd(0, 1, 0, 0);
    rnd(1, 0, 0, 0);
    rnd(0, 0, 1, 0);
    rnd(0, 1, 1, 0);
    repeat (2) rnd(0, 0, 1, 0);

    // 300 back-to-back ops from a fresh reset: sequence wraps past 255
    rnd(1, 0, 0, 0);
    repeat (300) rnd(0, 1, 1, 0);
    repeat (4) rnd(0, 0, 1, 0);

    // Random mix including stalls, clears and occasional resets
    for (int i = 0; i < 600; i++) begin
      rnd(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end

    // Drain with a bounded number of cycles
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      rnd(0, 0, 1, 0);
    end
    rnd(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
